// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the top_fifo write-port arbiter.
package fifo_arb_pkg;

    localparam int DATA_W_DEF = 36;

    typedef enum logic {IDLE, BURST} arb_state_t;

    // Cyclic successor of a round-robin pointer; nreq need not be a power of 2.
    function automatic int next_rr(input int ptr, input int nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request strictly after ptr, cyclically.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    int                  start_idx;
    int                  cand;
    logic [2*NREQ-1:0]   dbl;
    logic [NREQ-1:0]     rotated;

    // Rotate so bit 0 is the highest-priority request, find-first, then unrotate.
    assign start_idx = next_rr(int'(ptr), NREQ);
    assign dbl       = {req, req} >> start_idx;
    assign rotated   = dbl[NREQ-1:0];

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                cand  = start_idx + k;
                if (cand >= NREQ) cand = cand - NREQ;
                idx   = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one top_fifo write port among NREQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int MAX_BURST   = 4,
    parameter  int HF_THROTTLE = 1,
    localparam int PTR_W       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [DATA_W-1:0] req_data [NREQ],
    output logic [NREQ-1:0]   req_ready,
    input  logic              full,
    input  logic              half_full,
    output logic              WE,
    output logic [DATA_W-1:0] write_data,
    output logic [PTR_W-1:0]  grant_id,
    output logic              busy
);

    arb_state_t       state;
    logic [3:0]       beat_cnt;
    logic [3:0]       beat_nxt;
    logic [3:0]       quota;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] sel;
    logic             pick_found;
    logic             active;
    logic             accept;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign quota    = (HF_THROTTLE != 0 && half_full) ? 4'd1 : 4'(MAX_BURST);
    assign beat_nxt = beat_cnt + 4'd1;
    assign sel      = (state == BURST) ? grant_id : pick_idx;

    // Gating with reset keeps the write port silent while reset is held, even with valid inputs.
    assign active   = reset && ((state == BURST) || pick_found);
    assign accept   = active && req_valid[sel] && !full;

    always_comb begin
        req_ready = '0;
        if (active && !full) req_ready[sel] = 1'b1;
    end

    assign WE         = accept;
    assign write_data = accept ? req_data[sel] : '0;
    assign busy       = (state == BURST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= PTR_W'(NREQ - 1);
            beat_cnt <= 4'd0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= accept ? 4'd1 : 4'd0;
                        // Ownership locks even when full blocks the first beat.
                        if (accept && quota == 4'd1) rr_ptr <= pick_idx;
                        else                         state  <= BURST;
                    end
                end
                BURST: begin
                    if (!req_valid[grant_id]) begin
                        state  <= IDLE;
                        rr_ptr <= grant_id;
                    end else if (accept) begin
                        beat_cnt <= beat_nxt;
                        // >= also covers a quota that dropped below the count mid-burst.
                        if (beat_nxt >= quota) begin
                            state  <= IDLE;
                            rr_ptr <= grant_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, MAX_BURST=4, HF_THROTTLE=1).
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 36;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [DATA_W-1:0] req_data [NREQ];
    logic [NREQ-1:0]   req_ready;
    logic              full;
    logic              half_full;
    logic              WE;
    logic [DATA_W-1:0] write_data;
    logic [1:0]        grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(4), .HF_THROTTLE(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .full       (full),
        .half_full  (half_full),
        .WE         (WE),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] d(input int i);
        return 36'h9_0000_0000 | DATA_W'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int owner, input logic [DATA_W-1:0] data);
        chk({tag, " WE"}, 64'(WE), 64'd1);
        chk({tag, " data"}, 64'(write_data), 64'(data));
        chk({tag, " ready"}, 64'(req_ready), 64'(4'b0001 << owner));
    endtask

    task automatic idle_out(input string tag);
        chk({tag, " WE"}, 64'(WE), 64'd0);
        chk({tag, " data"}, 64'(write_data), 64'd0);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        req_valid = '0;
        half_full = 1'b0;
        full = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i] = d(i);
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        full      = 1'b0;
        half_full = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_data[i] = d(i);

        // Test 1: reset held with all requests valid
        for (int c = 0; c < 3; c++) begin
            #1;
            idle_out("rst");
            chk("rst ready", 64'(req_ready), 64'd0);
            chk("rst busy", 64'(busy), 64'd0);
            chk("rst grant", 64'(grant_id), 64'd0);
            step();
        end
        reset = 1'b1;
        #1;

        // Test 2: all valid, rotating bursts of 4, beat 0 is the reset-release cycle
        for (int b = 0; b <= 16; b++) begin
            beat($sformatf("rr b%0d", b), (b / 4) % 4, d((b / 4) % 4));
            chk($sformatf("rr b%0d grant", b), 64'(grant_id), (b == 0) ? 64'd0 : 64'(((b - 1) / 4) % 4));
            chk($sformatf("rr b%0d busy", b), 64'(busy), (b % 4 == 0) ? 64'd0 : 64'd1);
            step();
            #1;
        end

        // Test 3: req 2 alone with a 3-cycle full stall after beat 2
        do_reset();
        req_valid = 4'b0100;
        req_data[2] = 36'h1; #1; beat("st b1", 2, 36'h1); step();
        req_data[2] = 36'h2; #1; beat("st b2", 2, 36'h2); step();
        req_data[2] = 36'h3;
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            idle_out($sformatf("st full%0d", c));
            chk($sformatf("st full%0d ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("st full%0d busy", c), 64'(busy), 64'd1);
            step();
        end
        full = 1'b0;
        #1; beat("st b3", 2, 36'h3); step();
        req_data[2] = 36'h4; #1; beat("st b4", 2, 36'h4); step();
        req_data[2] = 36'h5; #1; beat("st b5", 2, 36'h5);
        chk("st b5 busy", 64'(busy), 64'd0);
        step();
        req_data[2] = 36'h6; #1; beat("st b6", 2, 36'h6); step();

        // Test 4: req 1 drops after 2 beats, req 3 takes over after one bubble
        do_reset();
        req_valid = 4'b1010;
        #1; beat("dr b1", 1, d(1)); step();
        #1; beat("dr b2", 1, d(1)); step();
        req_valid = 4'b1000;
        #1;
        idle_out("dr bubble");
        chk("dr bubble busy", 64'(busy), 64'd1);
        step();
        #1; beat("dr r3a", 3, d(3)); step();
        #1; beat("dr r3b", 3, d(3));
        chk("dr grant", 64'(grant_id), 64'd3);
        step();

        // Test 5: half_full throttle alternates owners every beat
        do_reset();
        half_full = 1'b1;
        req_valid = 4'b0011;
        for (int b = 0; b < 4; b++) begin
            #1;
            beat($sformatf("hf b%0d", b), b % 2, d(b % 2));
            chk($sformatf("hf b%0d busy", b), 64'(busy), 64'd0);
            step();
        end

        // Test 5b: quota drops mid-burst, owner releases after the next beat
        do_reset();
        req_valid = 4'b0011;
        #1; beat("qd b1", 0, d(0)); step();
        #1; beat("qd b2", 0, d(0)); step();
        half_full = 1'b1;
        #1; beat("qd b3", 0, d(0)); step();
        #1; beat("qd b4", 1, d(1)); step();

        // Test 6: reset mid-burst at beat 2 of req 1
        do_reset();
        req_valid = 4'b0010;
        #1; beat("mr b1", 1, d(1)); step();
        #1; beat("mr b2", 1, d(1));
        reset = 1'b0;
        #1;
        idle_out("mr rst");
        chk("mr rst ready", 64'(req_ready), 64'd0);
        chk("mr rst busy", 64'(busy), 64'd0);
        chk("mr rst grant", 64'(grant_id), 64'd0);
        step();
        req_valid = 4'b0011;
        reset = 1'b1;
        #1; beat("mr rel", 0, d(0));
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
